des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//  Iterative DES key scheduler, one subkey per handshake.
//  - Sits directly downstream of the PC-1 key permutation.
//  - Accepts the 56-bit permuted key (C0||D0) and rotates the C/D halves per round.
//  - Applies PC-2 internally and emits the 16 48-bit round subkeys in order over a
//    valid/ready stream to the round datapath.
//  - Decrypt mode emits K16..K1 using right rotations, with no key re-load.
// PARAMETERS
//  NUM_ROUNDS  16  round count; only 16 is supported (the shift table is fixed)
//  CD_W        56  width of the C||D input; fixed
//  SK_W        48  subkey width; fixed
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  key_valid    in   1   cd_in/decrypt are valid
//  key_ready    out  1   block can accept a key (IDLE)
//  cd_in        in   56  PC-1 output; [55] = DES bit 1; C0=[55:28], D0=[27:0]
//  decrypt      in   1   sampled with key: 0 = K1..K16 order, 1 = K16..K1 order
//  subkey_valid out  1   subkey/round_idx/last are valid
//  subkey_ready in   1   consumer accepts the current subkey
//  subkey       out  48  round subkey; [47] = DES bit 1
//  round_idx    out  4   emission index 0..15 (not the DES key number)
//  last         out  1   high with the 16th subkey of the sequence
//  busy         out  1   high in RUN
// BEHAVIOUR
//  - Reset (async assert, sync deassert expected): IDLE, key_ready=0 while rst is high,
//    subkey_valid=0, subkey=0, round_idx=0, last=0, busy=0.
//  - key_ready=1 in IDLE once out of reset.
//  - Shift table, rounds 1..16: S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
//  - PC-2: standard FIPS 46-3 table on 1-based C||D. subkey bit j = CD bit PC2[j].
//  - IDLE -> RUN on key_valid&&key_ready; decrypt is latched in the same cycle.
//      encrypt: C,D <= rotl(C0,1), rotl(D0,1);  subkey reg <= PC2(C1,D1) = K1
//      decrypt: C,D <= C0,D0 (C16==C0);         subkey reg <= PC2(C0,D0) = K16
//  - Latency: subkey_valid=1 on the cycle after acceptance; round_idx=0.
//  - RUN, subkey_valid && !subkey_ready: subkey, round_idx, last and C/D held stable.
//  - RUN, handshake on emission n<15 (n = round_idx): round_idx<=n+1; next subkey
//    registered so subkey_valid stays 1 (zero-bubble, 1 key/cycle at full rate).
//      encrypt: rotl by S[n+2] -> K(n+2)
//      decrypt: rotr by S[16-n] -> K(15-n)
//  - last = (round_idx==15).
//  - Handshake with last=1: -> IDLE. subkey_valid=0, round_idx=0, key_ready=1 the next
//    cycle. No key is accepted in the same cycle as the final handshake.
//  - cd_in/decrypt are ignored during RUN. key_valid in RUN is not an error; the
//    producer simply waits.
//  - Rotations are modulo 28 within each half; C and D never mix.
//  - rst mid-sequence: immediate return to reset values. A partial sequence is abandoned
//    and no further subkeys are emitted.
//  - subkey is a register output, never combinational from cd_in.
// TESTING
//  1. FIPS example: cd_in=56'hF0CCAAF556678F, decrypt=0, ready held 1
//     -> K1=48'h1B02EFFC7072 at round_idx 0, K16=48'hCB3D8B0E17F5 with last=1.
//     16 consecutive valid cycles; then key_ready=1.
//  2. Same key, decrypt=1 -> first subkey 48'hCB3D8B0E17F5, last 48'h1B02EFFC7072.
//     The full sequence equals the encrypt sequence reversed.
//  3. Backpressure: random subkey_ready (30% high)
//     -> sequence identical to test 1; outputs stable while stalled.
//     Exactly 16 handshakes are seen.
//  4. cd_in=0 and cd_in=56'hFFFFFFFFFFFFFF -> all subkeys 0 / all 48'hFFFFFFFFFFFF.
//     Also: key_valid pulsed during RUN is ignored.
//  5. Assert rst at round_idx=7 while stalled -> same cycle: subkey_valid=0, subkey=0,
//     busy=0. After release a new key restarts from round_idx 0 with a correct K1.
//  6. Back-to-back keys with key_valid held 1 -> second accepted exactly one cycle after
//     the final handshake. No subkeys are lost or duplicated.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out stream bundle for the iterative DES key scheduler.
// The slave side is the scheduler; the master side is the key producer plus round datapath.
interface des_key_schedule_if #(
  parameter int CD_W = 56,
  parameter int SK_W = 48
);
  logic            key_valid;
  logic            key_ready;
  logic [CD_W-1:0] cd_in;
  logic            decrypt;
  logic            subkey_valid;
  logic            subkey_ready;
  logic [SK_W-1:0] subkey;
  logic [3:0]      round_idx;
  logic            last;
  logic            busy;

  modport master (
    output key_valid, cd_in, decrypt, subkey_ready,
    input  key_ready, subkey_valid, subkey, round_idx, last, busy
  );

  modport slave (
    input  key_valid, cd_in, decrypt, subkey_ready,
    output key_ready, subkey_valid, subkey, round_idx, last, busy
  );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: takes PC-1 output (C0||D0), emits K1..K16 (or K16..K1)
// one per handshake, with PC-2 applied to the next C/D so the subkey is always registered.
module des_key_schedule #(
  parameter int NUM_ROUNDS = 16,
  parameter int CD_W       = 56,
  parameter int SK_W       = 48
) (
  input logic               clk,
  input logic               rst,
  des_key_schedule_if.slave kif
);
  localparam int HW = CD_W / 2;

  // PC-2 source positions, 1-based on C||D with position 1 at the MSB
  localparam int unsigned PC2 [SK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   c_q, d_q, c_nxt, d_nxt;
  logic [CD_W-1:0] cd_nxt;
  logic [SK_W-1:0] sk_q, sk_d;
  logic [3:0]      idx_q, idx_nxt;
  logic [4:0]      rnd;
  logic [1:0]      sh;
  logic            dec_q, dec_nxt, upd, key_rdy, last_w;

  // Per-round left-shift count, rounds 1..16
  function automatic logic [1:0] shamt(input logic [4:0] r);
    case (r)
      5'd1, 5'd2, 5'd9, 5'd16: shamt = 2'd1;
      default:                 shamt = 2'd2;
    endcase
  endfunction

  function automatic logic [HW-1:0] rotl(input logic [HW-1:0] x, input logic [1:0] s);
    rotl = (s == 2'd2) ? {x[HW-3:0], x[HW-1:HW-2]} : {x[HW-2:0], x[HW-1]};
  endfunction

  function automatic logic [HW-1:0] rotr(input logic [HW-1:0] x, input logic [1:0] s);
    rotr = (s == 2'd2) ? {x[1:0], x[HW-1:2]} : {x[0], x[HW-1:1]};
  endfunction

  assign key_rdy = (state == IDLE) && !rst;
  assign last_w  = (state == RUN) && (idx_q == 4'(NUM_ROUNDS - 1));
  assign cd_nxt  = {c_nxt, d_nxt};

  for (genvar j = 0; j < SK_W; j++) begin : g_pc2
    assign sk_d[SK_W-1-j] = cd_nxt[CD_W - PC2[j]];
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    dec_nxt   = dec_q;
    c_nxt     = c_q;
    d_nxt     = d_q;
    upd       = 1'b0;
    rnd       = 5'd0;
    sh        = 2'd1;
    case (state)
      IDLE: begin
        if (kif.key_valid && key_rdy) begin
          state_nxt = RUN;
          idx_nxt   = 4'd0;
          dec_nxt   = kif.decrypt;
          upd       = 1'b1;
          // decrypt starts from C16/D16, which equal C0/D0 after the full 28-bit rotation
          if (kif.decrypt) begin
            c_nxt = kif.cd_in[CD_W-1:HW];
            d_nxt = kif.cd_in[HW-1:0];
          end else begin
            c_nxt = rotl(kif.cd_in[CD_W-1:HW], 2'd1);
            d_nxt = rotl(kif.cd_in[HW-1:0], 2'd1);
          end
        end
      end
      RUN: begin
        if (kif.subkey_ready) begin
          if (last_w) begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt = idx_q + 4'd1;
            upd     = 1'b1;
            rnd     = dec_q ? (5'd16 - {1'b0, idx_q}) : ({1'b0, idx_q} + 5'd2);
            sh      = shamt(rnd);
            c_nxt   = dec_q ? rotr(c_q, sh) : rotl(c_q, sh);
            d_nxt   = dec_q ? rotr(d_q, sh) : rotl(d_q, sh);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      c_q   <= '0;
      d_q   <= '0;
      sk_q  <= '0;
      idx_q <= '0;
      dec_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      dec_q <= dec_nxt;
      if (upd) begin
        {c_q, d_q} <= cd_nxt;
        sk_q       <= sk_d;
      end
    end
  end

  assign kif.key_ready    = key_rdy;
  assign kif.subkey_valid = (state == RUN);
  assign kif.subkey       = sk_q;
  assign kif.round_idx    = idx_q;
  assign kif.last         = last_w;
  assign kif.busy         = (state == RUN);
endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a closed-form key schedule model.
module tb_des_key_schedule;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_key_schedule_if ifc ();
  des_key_schedule dut (.clk(clk), .rst(rst), .kif(ifc));

  int errs = 0;
  int checks = 0;

  int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [55:0] FIPS_CD = 56'hF0CCAAF556678F;
  localparam logic [47:0] FIPS_K1 = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

  logic [47:0] got_sk[$];
  int          got_idx[$];
  bit          got_last[$];
  int          gaps, stall_bad;
  bit          timeout, first_valid;
  logic [47:0] enc_seq[16];

  // Kk from C0/D0 rotated left by the cumulative shift total of rounds 1..k
  function automatic logic [47:0] model_key(input logic [55:0] key, input int k);
    int tot = 0;
    logic [55:0] cc, dd, cd;
    logic [47:0] sk;
    for (int r = 0; r < k; r++) tot += SH[r];
    tot = tot % 28;
    cc = {key[55:28], key[55:28]} << tot;
    dd = {key[27:0], key[27:0]} << tot;
    cd = {cc[55:28], dd[55:28]};
    for (int j = 0; j < 48; j++) sk[47-j] = cd[56 - PC2[j]];
    return sk;
  endfunction

  function automatic logic [47:0] model_emit(input logic [55:0] key, input bit dec, input int i);
    return dec ? model_key(key, 16 - i) : model_key(key, i + 1);
  endfunction

  function automatic logic [55:0] rand56();
    return 56'({$urandom(), $urandom()});
  endfunction

  // Drives one key and records every handshaken subkey; no judgement here.
  task automatic collect(input logic [55:0] key, input bit dec, input int rpct, input bit pulse_kv);
    int cyc;
    bit done, stalled, rdy;
    logic [47:0] psk;
    logic [3:0] pidx;
    logic plast;
    got_sk.delete(); got_idx.delete(); got_last.delete();
    gaps = 0; stall_bad = 0; timeout = 0; cyc = 0; done = 0; stalled = 0;
    psk = '0; pidx = '0; plast = 1'b0;
    @(negedge clk);
    while (!ifc.key_ready && cyc < 100) begin @(negedge clk); cyc++; end
    ifc.key_valid = 1'b1; ifc.cd_in = key; ifc.decrypt = dec;
    @(negedge clk);
    ifc.key_valid = 1'b0; ifc.cd_in = rand56(); ifc.decrypt = 1'($urandom());
    first_valid = ifc.subkey_valid && (ifc.round_idx == 4'd0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (stalled && (ifc.subkey_valid !== 1'b1 || ifc.subkey !== psk ||
                      ifc.round_idx !== pidx || ifc.last !== plast)) stall_bad++;
      if (pulse_kv) begin ifc.key_valid = 1'($urandom()); ifc.cd_in = rand56(); end
      if (ifc.subkey_valid) begin
        rdy = (int'($urandom_range(0, 99)) < rpct);
        ifc.subkey_ready = rdy;
        if (rdy) begin
          got_sk.push_back(ifc.subkey);
          got_idx.push_back(int'(ifc.round_idx));
          got_last.push_back(ifc.last);
          done = ifc.last;
          stalled = 0;
        end else begin
          stalled = 1; psk = ifc.subkey; pidx = ifc.round_idx; plast = ifc.last;
        end
      end else begin
        gaps++;
        ifc.subkey_ready = 1'($urandom());
        stalled = 0;
      end
      @(negedge clk); cyc++;
    end
    ifc.key_valid = 1'b0; ifc.subkey_ready = 1'b0;
    timeout = !done;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ifc.key_ready !== 1'b0) begin errs++; $display("FAIL rst_key_ready: got %b want 0", ifc.key_ready); end
    checks++; if (ifc.subkey_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", ifc.subkey_valid); end
    checks++; if (ifc.subkey !== 48'h0) begin errs++; $display("FAIL rst_subkey: got %h want 0", ifc.subkey); end
    checks++; if (ifc.round_idx !== 4'd0 || ifc.last !== 1'b0 || ifc.busy !== 1'b0) begin
      errs++; $display("FAIL rst_idx_last_busy: got %0d/%b/%b want 0/0/0", ifc.round_idx, ifc.last, ifc.busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ifc.key_ready !== 1'b1) begin errs++; $display("FAIL idle_key_ready: got %b want 1", ifc.key_ready); end
  endtask

  task automatic test_fips_encrypt();
    collect(FIPS_CD, 1'b0, 100, 1'b0);
    checks++; if (timeout) begin errs++; $display("FAIL enc_timeout: got timeout want last"); end
    checks++; if (!first_valid) begin errs++; $display("FAIL enc_latency: got no valid idx0 want valid idx0 one cycle after accept"); end
    checks++; if (got_sk.size() !== 16) begin errs++; $display("FAIL enc_count: got %0d want 16", got_sk.size()); end
    checks++; if (gaps !== 0) begin errs++; $display("FAIL enc_bubbles: got %0d want 0", gaps); end
    for (int i = 0; i < got_sk.size(); i++) begin
      checks++; if (got_sk[i] !== model_emit(FIPS_CD, 1'b0, i) || got_idx[i] !== i || got_last[i] !== (i == 15)) begin
        errs++; $display("FAIL enc_k%0d: got %h idx %0d last %b want %h idx %0d last %b", i,
                         got_sk[i], got_idx[i], got_last[i], model_emit(FIPS_CD, 1'b0, i), i, (i == 15)); end
      if (i < 16) enc_seq[i] = got_sk[i];
    end
    if (got_sk.size() == 16) begin
      checks++; if (got_sk[0] !== FIPS_K1) begin errs++; $display("FAIL enc_fips_k1: got %h want %h", got_sk[0], FIPS_K1); end
      checks++; if (got_sk[15] !== FIPS_K16) begin errs++; $display("FAIL enc_fips_k16: got %h want %h", got_sk[15], FIPS_K16); end
    end
    checks++; if (ifc.key_ready !== 1'b1 || ifc.subkey_valid !== 1'b0 || ifc.round_idx !== 4'd0) begin
      errs++; $display("FAIL enc_back_idle: got rdy %b vld %b idx %0d want 1 0 0", ifc.key_ready, ifc.subkey_valid, ifc.round_idx); end
  endtask

  task automatic test_fips_decrypt();
    collect(FIPS_CD, 1'b1, 100, 1'b0);
    checks++; if (timeout || got_sk.size() !== 16) begin errs++; $display("FAIL dec_count: got %0d want 16", got_sk.size()); end
    for (int i = 0; i < got_sk.size() && i < 16; i++) begin
      checks++; if (got_sk[i] !== model_emit(FIPS_CD, 1'b1, i) || got_sk[i] !== enc_seq[15-i] || got_idx[i] !== i) begin
        errs++; $display("FAIL dec_k%0d: got %h idx %0d want %h idx %0d", i, got_sk[i], got_idx[i], enc_seq[15-i], i); end
    end
    if (got_sk.size() == 16) begin
      checks++; if (got_sk[0] !== FIPS_K16) begin errs++; $display("FAIL dec_first: got %h want %h", got_sk[0], FIPS_K16); end
      checks++; if (got_sk[15] !== FIPS_K1 || got_last[15] !== 1'b1) begin
        errs++; $display("FAIL dec_last: got %h last %b want %h last 1", got_sk[15], got_last[15], FIPS_K1); end
    end
  endtask

  task automatic test_backpressure();
    logic [55:0] k;
    bit d;
    collect(FIPS_CD, 1'b0, 30, 1'b0);
    checks++; if (timeout || got_sk.size() !== 16) begin errs++; $display("FAIL bp_count: got %0d want 16", got_sk.size()); end
    checks++; if (stall_bad !== 0) begin errs++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad); end
    for (int i = 0; i < got_sk.size() && i < 16; i++) begin
      checks++; if (got_sk[i] !== enc_seq[i] || got_idx[i] !== i) begin
        errs++; $display("FAIL bp_k%0d: got %h idx %0d want %h idx %0d", i, got_sk[i], got_idx[i], enc_seq[i], i); end
    end
    for (int t = 0; t < 4; t++) begin
      k = rand56(); d = 1'($urandom());
      collect(k, d, 50, 1'b0);
      checks++; if (timeout || got_sk.size() !== 16 || stall_bad !== 0) begin
        errs++; $display("FAIL rnd%0d_count: got %0d stalls_bad %0d want 16 0", t, got_sk.size(), stall_bad); end
      for (int i = 0; i < got_sk.size() && i < 16; i++) begin
        checks++; if (got_sk[i] !== model_emit(k, d, i)) begin
          errs++; $display("FAIL rnd%0d_k%0d: got %h want %h", t, i, got_sk[i], model_emit(k, d, i)); end
      end
    end
  endtask

  task automatic test_extremes();
    collect(56'h0, 1'b0, 100, 1'b1);
    checks++; if (got_sk.size() !== 16) begin errs++; $display("FAIL zero_count: got %0d want 16", got_sk.size()); end
    for (int i = 0; i < got_sk.size(); i++) begin
      checks++; if (got_sk[i] !== 48'h0) begin errs++; $display("FAIL zero_k%0d: got %h want 0", i, got_sk[i]); end
    end
    collect(56'hFFFFFFFFFFFFFF, 1'($urandom()), 100, 1'b1);
    checks++; if (got_sk.size() !== 16) begin errs++; $display("FAIL ones_count: got %0d want 16", got_sk.size()); end
    for (int i = 0; i < got_sk.size(); i++) begin
      checks++; if (got_sk[i] !== 48'hFFFFFFFFFFFF) begin errs++; $display("FAIL ones_k%0d: got %h want ffffffffffff", i, got_sk[i]); end
    end
  endtask

  task automatic test_reset_midseq();
    logic [55:0] k;
    int cyc = 0;
    k = rand56();
    @(negedge clk);
    while (!ifc.key_ready && cyc < 100) begin @(negedge clk); cyc++; end
    ifc.key_valid = 1'b1; ifc.cd_in = k; ifc.decrypt = 1'b0;
    @(negedge clk);
    ifc.key_valid = 1'b0; ifc.subkey_ready = 1'b1;
    cyc = 0;
    while (ifc.round_idx !== 4'd7 && cyc < 100) begin @(negedge clk); cyc++; end
    ifc.subkey_ready = 1'b0;
    @(negedge clk);
    checks++; if (ifc.round_idx !== 4'd7 || ifc.busy !== 1'b1 || ifc.subkey !== model_emit(k, 1'b0, 7)) begin
      errs++; $display("FAIL mid_stall: got idx %0d busy %b sk %h want 7 1 %h", ifc.round_idx, ifc.busy, ifc.subkey, model_emit(k, 1'b0, 7)); end
    rst = 1'b1;
    #1;
    checks++; if (ifc.subkey_valid !== 1'b0 || ifc.subkey !== 48'h0 || ifc.busy !== 1'b0 || ifc.round_idx !== 4'd0) begin
      errs++; $display("FAIL mid_rst: got vld %b sk %h busy %b idx %0d want 0 0 0 0", ifc.subkey_valid, ifc.subkey, ifc.busy, ifc.round_idx); end
    @(negedge clk);
    rst = 1'b0;
    k = rand56();
    collect(k, 1'b0, 100, 1'b0);
    checks++; if (got_sk.size() !== 16 || got_sk[0] !== model_key(k, 1) || got_idx[0] !== 0) begin
      errs++; $display("FAIL mid_restart: got n %0d k1 %h want 16 %h", got_sk.size(), (got_sk.size() > 0) ? got_sk[0] : 48'h0, model_key(k, 1)); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] ka, kb;
    bit da, db, kr_seen;
    int n = 0, cyc = 0, g = 0;
    ka = rand56(); kb = rand56(); da = 1'($urandom()); db = 1'($urandom());
    kr_seen = 0;
    got_sk.delete(); got_idx.delete();
    @(negedge clk);
    while (!ifc.key_ready && cyc < 100) begin @(negedge clk); cyc++; end
    ifc.key_valid = 1'b1; ifc.cd_in = ka; ifc.decrypt = da;
    @(negedge clk);
    ifc.cd_in = kb; ifc.decrypt = db; ifc.subkey_ready = 1'b1;
    cyc = 0;
    while (n < 32 && cyc < 200) begin
      if (ifc.subkey_valid) begin
        got_sk.push_back(ifc.subkey);
        got_idx.push_back(int'(ifc.round_idx));
        if (n == 16) ifc.key_valid = 1'b0;
        n++;
      end else begin
        g++;
        if (n == 16) kr_seen = ifc.key_ready;
      end
      @(negedge clk); cyc++;
    end
    ifc.key_valid = 1'b0; ifc.subkey_ready = 1'b0;
    checks++; if (n !== 32) begin errs++; $display("FAIL b2b_count: got %0d want 32", n); end
    checks++; if (g !== 1 || !kr_seen) begin errs++; $display("FAIL b2b_gap: got %0d idle cycles rdy %b want 1 1", g, kr_seen); end
    for (int i = 0; i < got_sk.size(); i++) begin
      checks++; if (got_sk[i] !== ((i < 16) ? model_emit(ka, da, i) : model_emit(kb, db, i - 16)) || got_idx[i] !== (i % 16)) begin
        errs++; $display("FAIL b2b_k%0d: got %h idx %0d want %h idx %0d", i, got_sk[i], got_idx[i],
                         (i < 16) ? model_emit(ka, da, i) : model_emit(kb, db, i - 16), i % 16); end
    end
  endtask

  initial begin
    ifc.key_valid = 1'b0; ifc.cd_in = '0; ifc.decrypt = 1'b0; ifc.subkey_ready = 1'b0;
    test_reset();
    test_fips_encrypt();
    test_fips_decrypt();
    test_backpressure();
    test_extremes();
    test_reset_midseq();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
